// File: rtl/jt5205_nibble_feed.sv
// Byte FIFO feeding an ADPCM decoder one 4-bit code per cen_lo slot.
// Emits a vck pop pulse, and a +/- idle pattern whenever no data is available or playback is stopped.
module jt5205_nibble_feed #(
  parameter int AW       = 2,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cen_lo_i,
  input  logic          start_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic [3:0]    din_o,
  output logic          vck_o,
  output logic          underrun_o,
  output logic [7:0]    under_cnt_o,
  output logic          overflow_o
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          pend_q, phase_q;
  logic [3:0]    hold_q, din_q;
  logic          vck_q, under_q, ovf_q;
  logic [7:0]    ucnt_q;

  logic       empty, full, pop, push, drop;
  logic [7:0] rd_byte;
  logic [3:0] first_nib, second_nib, idle_nib;

  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == DEPTH_L);
    // Empty is the registered state, so a same-cycle write cannot be popped.
    pop        = cen_lo_i & start_i & ~pend_q & ~empty;
    push       = wr_i & (~full | pop);
    drop       = wr_i & full & ~pop;
    rd_byte    = mem_q[rptr_q];
    first_nib  = HI_FIRST ? rd_byte[7:4] : rd_byte[3:0];
    second_nib = HI_FIRST ? rd_byte[3:0] : rd_byte[7:4];
    idle_nib   = {phase_q, 3'b000};
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      pend_q  <= 1'b0;
      phase_q <= 1'b0;
      hold_q  <= '0;
      din_q   <= '0;
      vck_q   <= 1'b0;
      under_q <= 1'b0;
      ucnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      vck_q   <= pop;
      under_q <= 1'b0;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop) ovf_q <= 1'b1;
      if (cen_lo_i) begin
        if (start_i && pend_q) begin
          din_q  <= hold_q;
          pend_q <= 1'b0;
        end else if (start_i && !empty) begin
          din_q  <= first_nib;
          hold_q <= second_nib;
          pend_q <= 1'b1;
        end else begin
          // Idle slot: alternate +delta/-delta so the decoder stays near rest.
          if (start_i) begin
            under_q <= 1'b1;
            if (ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 1'b1;
          end
          pend_q  <= 1'b0;
          din_q   <= idle_nib;
          phase_q <= ~phase_q;
        end
      end
    end
  end

  assign full_o      = full;
  assign empty_o     = empty;
  assign level_o     = level_q;
  assign din_o       = din_q;
  assign vck_o       = vck_q;
  assign underrun_o  = under_q;
  assign under_cnt_o = ucnt_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_jt5205_nibble_feed.sv
// Directed bench for jt5205_nibble_feed: a vector table for basic playback,
// plus hand sequences for underrun, overflow, pop/write overlap, stop and reset.
module tb_jt5205_nibble_feed;

  localparam int AW = 2;

  logic       clk = 1'b0;
  logic       rst_n, cen_lo, start, wr;
  logic [7:0] wdata;
  logic       full, empty, vck, underrun, overflow;
  logic [AW:0] level;
  logic [3:0] din;
  logic [7:0] under_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jt5205_nibble_feed #(.AW(AW), .HI_FIRST(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cen_lo_i(cen_lo), .start_i(start),
    .wr_i(wr), .wdata_i(wdata), .full_o(full), .empty_o(empty),
    .level_o(level), .din_o(din), .vck_o(vck), .underrun_o(underrun),
    .under_cnt_o(under_cnt), .overflow_o(overflow)
  );

  typedef struct {
    logic       cen, st, w;
    logic [7:0] d;
    logic [3:0] e_din;
    logic       e_vck, e_un;
    logic [2:0] e_lvl;
    logic       e_full, e_empty;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic rn, input logic c, input logic s, input logic w, input logic [7:0] d);
    @(negedge clk);
    rst_n = rn; cen_lo = c; start = s; wr = w; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic play(input string name, input logic [3:0] exp_din);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    chk(name, din, exp_din);
  endtask

  initial begin
    rst_n = 1'b0; cen_lo = 1'b0; start = 1'b0; wr = 1'b0; wdata = '0;

    //            cen st  w  data   din  vck un lvl full empty cnt
    vecs[0] = '{1'b0,1'b0,1'b1,8'hA3,4'h0,1'b0,1'b0,3'd1,1'b0,1'b0,8'd0};
    vecs[1] = '{1'b0,1'b0,1'b1,8'h5C,4'h0,1'b0,1'b0,3'd2,1'b0,1'b0,8'd0};
    vecs[2] = '{1'b1,1'b1,1'b0,8'h00,4'hA,1'b1,1'b0,3'd1,1'b0,1'b0,8'd0};
    vecs[3] = '{1'b1,1'b1,1'b0,8'h00,4'h3,1'b0,1'b0,3'd1,1'b0,1'b0,8'd0};
    vecs[4] = '{1'b1,1'b1,1'b0,8'h00,4'h5,1'b1,1'b0,3'd0,1'b0,1'b1,8'd0};
    vecs[5] = '{1'b1,1'b1,1'b0,8'h00,4'hC,1'b0,1'b0,3'd0,1'b0,1'b1,8'd0};
    vecs[6] = '{1'b0,1'b1,1'b0,8'h00,4'hC,1'b0,1'b0,3'd0,1'b0,1'b1,8'd0};
    vecs[7] = '{1'b1,1'b1,1'b0,8'h00,4'h0,1'b0,1'b1,3'd0,1'b0,1'b1,8'd1};
    vecs[8] = '{1'b1,1'b0,1'b0,8'h00,4'h8,1'b0,1'b0,3'd0,1'b0,1'b1,8'd1};
    vecs[9] = '{1'b0,1'b0,1'b0,8'h00,4'h8,1'b0,1'b0,3'd0,1'b0,1'b1,8'd1};

    // Reset state
    do_reset();
    chk("rst_din", din, 0);     chk("rst_vck", vck, 0);
    chk("rst_un", underrun, 0); chk("rst_cnt", under_cnt, 0);
    chk("rst_ovf", overflow, 0); chk("rst_lvl", level, 0);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0);

    // T1: running with no data -> idle pattern and underrun each slot
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      chk("t1_din", din, (i % 2) ? 8 : 0);
      chk("t1_un", underrun, 1);
      chk("t1_vck", vck, 0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("t1_hold", din, (i % 2) ? 8 : 0);
      chk("t1_unpulse", underrun, 0);
    end
    chk("t1_cnt", under_cnt, 4);

    // T2 table: prefill A3,5C then play
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].cen, vecs[i].st, vecs[i].w, vecs[i].d);
      chk($sformatf("v%0d_din", i), din, vecs[i].e_din);
      chk($sformatf("v%0d_vck", i), vck, vecs[i].e_vck);
      chk($sformatf("v%0d_un", i), underrun, vecs[i].e_un);
      chk($sformatf("v%0d_lvl", i), level, vecs[i].e_lvl);
      chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].e_empty);
      chk($sformatf("v%0d_cnt", i), under_cnt, vecs[i].e_cnt);
    end

    // T3: overfill with start=0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11 * (i + 1));
      chk("t3_lvl", level, (i < 4) ? i + 1 : 4);
      chk("t3_full", full, (i >= 3) ? 1 : 0);
      chk("t3_ovf", overflow, (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) play("t3_din", 4'(i / 2 + 1));
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("t3_tail_din", din, 0);
    chk("t3_tail_un", underrun, 1);
    chk("t3_ovf_sticky", overflow, 1);

    // T4: write to full FIFO coincides with a pop slot
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11 * (i + 1));
    chk("t4_full_pre", full, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    chk("t4_din", din, 1);    chk("t4_vck", vck, 1);
    chk("t4_lvl", level, 4);  chk("t4_full", full, 1);
    chk("t4_ovf", overflow, 0);
    play("t4_p0", 4'h1);
    play("t4_p1", 4'h2); play("t4_p2", 4'h2);
    play("t4_p3", 4'h3); play("t4_p4", 4'h3);
    play("t4_p5", 4'h4); play("t4_p6", 4'h4);
    play("t4_p7", 4'h9); play("t4_p8", 4'h9);
    chk("t4_empty", empty, 1);

    // T5: stop after first nibble discards the held nibble only
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h7E);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h12);
    play("t5_first", 4'h7);
    chk("t5_lvl1", level, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("t5_idle", din, 0);
    chk("t5_lvl2", level, 1);
    chk("t5_noun", underrun, 0);
    play("t5_resume", 4'h1);
    play("t5_resume2", 4'h2);

    // Write and pop-slot together on an empty FIFO -> underrun, byte next slot
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hB4);
    chk("we_un", underrun, 1); chk("we_lvl", level, 1); chk("we_vck", vck, 0);
    play("we_next", 4'hB);

    // T6: counter saturation then mid-run reset
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("t6_sat", under_cnt, 255);
    chk("t6_din", din, 8);
    chk("t6_un", underrun, 1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h42);
    chk("t6_ovf", overflow, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    chk("t6r_din", din, 0);   chk("t6r_vck", vck, 0);
    chk("t6r_un", underrun, 0); chk("t6r_cnt", under_cnt, 0);
    chk("t6r_ovf", overflow, 0); chk("t6r_lvl", level, 0);
    chk("t6r_empty", empty, 1); chk("t6r_full", full, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
